// File: rtl/commit_queue_mw.sv
// In-order commit queue: multi-lane dispatch, out-of-order completion, in-order retire.
// Wrap-bit head/tail pointers distinguish full from empty.
module commit_queue_mw #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ID_W       = $clog2(DEPTH),
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned COMPLETE_P = 2,
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LREG_W     = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [DISPATCH_W-1:0]        dispatch_en,
    input  logic [DISPATCH_W-1:0]        dispatch_kind,
    input  logic [DISPATCH_W*LREG_W-1:0] dispatch_dest,
    output logic                         dispatch_reject,
    output logic [ID_W-1:0]              dispatch_id,
    input  logic [COMPLETE_P-1:0]        complete_en,
    input  logic [COMPLETE_P*ID_W-1:0]   complete_id,
    input  logic [COMPLETE_P*DATA_W-1:0] complete_data,
    input  logic [COMPLETE_P-1:0]        complete_miss,
    input  logic [COMPLETE_P-1:0]        complete_taken,
    input  logic                         commit_stall,
    output logic [COMMIT_W-1:0]          commit_en,
    output logic [COMMIT_W*LREG_W-1:0]   commit_dest,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic                         branch_en,
    output logic                         branch_miss,
    output logic                         branch_taken,
    output logic [DATA_W-1:0]            branch_jump_addr,
    output logic [ID_W:0]                count,
    output logic                         empty
);
    localparam int unsigned PTR_W = ID_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d, fin_q, fin_d, kind_q, kind_d;
    logic [DEPTH-1:0]  miss_q, miss_d, taken_q, taken_d;
    logic [LREG_W-1:0] dest_q [DEPTH];
    logic [LREG_W-1:0] dest_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PTR_W-1:0]    occ, free_slots, n_ret, n_disp;
    logic [COMMIT_W-1:0] lane_ok;
    logic [DEPTH-1:0]    ret_mask;
    logic [ID_W-1:0]     head_idx, ret_idx, cmp_idx, disp_idx;
    logic                run;

    assign occ             = tail_q - head_q;
    assign free_slots      = PTR_W'(DEPTH) - occ;
    assign count           = occ;
    assign empty           = (head_q == tail_q);
    assign dispatch_reject = (free_slots < PTR_W'(DISPATCH_W));
    assign dispatch_id     = tail_q[ID_W-1:0];
    assign head_idx        = head_q[ID_W-1:0];

    // Retire window: contiguous finished entries from head; a branch only ever retires alone in lane 0.
    always_comb begin
        lane_ok     = '0;
        ret_mask    = '0;
        n_ret       = '0;
        ret_idx     = head_idx;
        run         = !commit_stall;
        commit_en   = '0;
        commit_dest = '0;
        commit_data = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            ret_idx = head_idx + ID_W'(k);
            if (PTR_W'(k) >= occ) begin
                run = 1'b0;
            end
            if (!valid_q[ret_idx] || !fin_q[ret_idx]) begin
                run = 1'b0;
            end
            if ((k > 0) && (kind_q[head_idx] || kind_q[ret_idx])) begin
                run = 1'b0;
            end
            lane_ok[k] = run;
            if (run) begin
                ret_mask[ret_idx] = 1'b1;
                n_ret             = n_ret + PTR_W'(1);
                if (!kind_q[ret_idx]) begin
                    commit_en[k]                        = 1'b1;
                    commit_dest[k*LREG_W +: LREG_W]     = dest_q[ret_idx];
                    commit_data[k*DATA_W +: DATA_W]     = data_q[ret_idx];
                end
            end
        end
    end

    assign branch_en        = lane_ok[0] & kind_q[head_idx];
    assign branch_miss      = branch_en & miss_q[head_idx];
    assign branch_taken     = branch_en & taken_q[head_idx];
    assign branch_jump_addr = branch_en ? data_q[head_idx] : '0;

    // Next state: completion, then retire, then dispatch; flush overrides everything.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        valid_d  = valid_q;
        fin_d    = fin_q;
        kind_d   = kind_q;
        miss_d   = miss_q;
        taken_d  = taken_q;
        dest_d   = dest_q;
        data_d   = data_q;
        n_disp   = '0;
        cmp_idx  = '0;
        disp_idx = '0;

        // Later ports overwrite earlier ones when they target the same entry.
        for (int p = 0; p < COMPLETE_P; p++) begin
            if (complete_en[p]) begin
                cmp_idx = complete_id[p*ID_W +: ID_W];
                if (valid_q[cmp_idx] && !ret_mask[cmp_idx]) begin
                    fin_d[cmp_idx]   = 1'b1;
                    data_d[cmp_idx]  = complete_data[p*DATA_W +: DATA_W];
                    miss_d[cmp_idx]  = complete_miss[p];
                    taken_d[cmp_idx] = complete_taken[p];
                end
            end
        end

        valid_d = valid_d & ~ret_mask;
        fin_d   = fin_d & ~ret_mask;
        head_d  = head_q + n_ret;

        if (!dispatch_reject) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (dispatch_en[i]) begin
                    disp_idx         = tail_q[ID_W-1:0] + ID_W'(i);
                    valid_d[disp_idx] = 1'b1;
                    fin_d[disp_idx]   = 1'b0;
                    kind_d[disp_idx]  = dispatch_kind[i];
                    dest_d[disp_idx]  = dispatch_dest[i*LREG_W +: LREG_W];
                    n_disp            = n_disp + PTR_W'(1);
                end
            end
            tail_d = tail_q + n_disp;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            fin_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            fin_q   <= '0;
            kind_q  <= '0;
            miss_q  <= '0;
            taken_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            fin_q   <= fin_d;
            kind_q  <= kind_d;
            miss_q  <= miss_d;
            taken_q <= taken_d;
        end
    end

    // Payload storage is qualified by valid/fin and needs no reset.
    always_ff @(posedge clock) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_commit_queue_mw.sv
// Scoreboard bench for commit_queue_mw (DEPTH=8): a program-order queue model predicts
// status and retire records; a separate monitor pops and compares them.
module tb_commit_queue_mw;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned DW     = 2;
    localparam int unsigned CP     = 2;
    localparam int unsigned CW     = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LREG_W = 5;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush;
    logic [DW-1:0]          dispatch_en, dispatch_kind;
    logic [DW*LREG_W-1:0]   dispatch_dest;
    logic                   dispatch_reject;
    logic [ID_W-1:0]        dispatch_id;
    logic [CP-1:0]          complete_en;
    logic [CP*ID_W-1:0]     complete_id;
    logic [CP*DATA_W-1:0]   complete_data;
    logic [CP-1:0]          complete_miss, complete_taken;
    logic                   commit_stall;
    logic [CW-1:0]          commit_en;
    logic [CW*LREG_W-1:0]   commit_dest;
    logic [CW*DATA_W-1:0]   commit_data;
    logic                   branch_en, branch_miss, branch_taken;
    logic [DATA_W-1:0]      branch_jump_addr;
    logic [ID_W:0]          count;
    logic                   empty;

    commit_queue_mw #(
        .DEPTH(DEPTH), .ID_W(ID_W), .DISPATCH_W(DW), .COMPLETE_P(CP),
        .COMMIT_W(CW), .DATA_W(DATA_W), .LREG_W(LREG_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_kind(dispatch_kind), .dispatch_dest(dispatch_dest),
        .dispatch_reject(dispatch_reject), .dispatch_id(dispatch_id),
        .complete_en(complete_en), .complete_id(complete_id), .complete_data(complete_data),
        .complete_miss(complete_miss), .complete_taken(complete_taken),
        .commit_stall(commit_stall), .commit_en(commit_en), .commit_dest(commit_dest),
        .commit_data(commit_data), .branch_en(branch_en), .branch_miss(branch_miss),
        .branch_taken(branch_taken), .branch_jump_addr(branch_jump_addr),
        .count(count), .empty(empty)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic              kind;
        logic [LREG_W-1:0] dest;
        logic              fin;
        logic [DATA_W-1:0] data;
        logic              miss;
        logic              taken;
    } ent_t;

    typedef struct {
        int cnt;
        bit rej;
        int did;
        bit any;
    } stat_t;

    typedef struct {
        bit                   br;
        logic [CW-1:0]        en;
        logic [CW*LREG_W-1:0] dest;
        logic [CW*DATA_W-1:0] data;
        bit                   miss;
        bit                   taken;
        logic [DATA_W-1:0]    addr;
    } ret_t;

    ent_t  m_q[$];
    int    m_head;
    stat_t stat_q[$];
    ret_t  ret_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    mon_on   = 1'b0;
    stat_t mon_s;
    ret_t  mon_r;
    bit    dut_any;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, from the program-order model.
    task automatic model_pre(output int nret);
        stat_t s;
        ret_t  r;
        int    sz;
        sz   = m_q.size();
        nret = 0;
        if (!commit_stall && sz > 0 && m_q[0].fin) begin
            nret = 1;
            if (!m_q[0].kind) begin
                while (nret < int'(CW) && nret < sz && m_q[nret].fin && !m_q[nret].kind) nret++;
            end
        end
        s.cnt = sz;
        s.rej = (int'(DEPTH) - sz) < int'(DW);
        s.did = (m_head + sz) % int'(DEPTH);
        s.any = (nret > 0);
        stat_q.push_back(s);
        if (nret > 0) begin
            r.br = 1'b0; r.en = '0; r.dest = '0; r.data = '0;
            r.miss = 1'b0; r.taken = 1'b0; r.addr = '0;
            if (m_q[0].kind) begin
                r.br    = 1'b1;
                r.miss  = m_q[0].miss;
                r.taken = m_q[0].taken;
                r.addr  = m_q[0].data;
            end else begin
                for (int k = 0; k < nret; k++) begin
                    r.en[k]                      = 1'b1;
                    r.dest[k*LREG_W +: LREG_W]   = m_q[k].dest;
                    r.data[k*DATA_W +: DATA_W]   = m_q[k].data;
                end
            end
            ret_q.push_back(r);
        end
    endtask

    // State after the coming edge.
    task automatic model_post(input int nret);
        bit   rej;
        int   id, pos;
        ent_t e;
        if (flush) begin
            m_q.delete();
            m_head = 0;
            return;
        end
        rej = (int'(DEPTH) - m_q.size()) < int'(DW);
        for (int p = 0; p < int'(CP); p++) begin
            if (complete_en[p]) begin
                id  = int'(complete_id[p*ID_W +: ID_W]);
                pos = (id - (m_head % int'(DEPTH)) + int'(DEPTH)) % int'(DEPTH);
                if (pos < m_q.size() && pos >= nret) begin
                    e       = m_q[pos];
                    e.fin   = 1'b1;
                    e.data  = complete_data[p*DATA_W +: DATA_W];
                    e.miss  = complete_miss[p];
                    e.taken = complete_taken[p];
                    m_q[pos] = e;
                end
            end
        end
        for (int k = 0; k < nret; k++) void'(m_q.pop_front());
        m_head = (m_head + nret) % (2 * int'(DEPTH));
        if (!rej) begin
            for (int i = 0; i < int'(DW); i++) begin
                if (dispatch_en[i]) begin
                    e.kind  = dispatch_kind[i];
                    e.dest  = dispatch_dest[i*LREG_W +: LREG_W];
                    e.fin   = 1'b0;
                    e.data  = '0;
                    e.miss  = 1'b0;
                    e.taken = 1'b0;
                    m_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        dispatch_en    = '0;
        dispatch_kind  = '0;
        dispatch_dest  = '0;
        complete_en    = '0;
        complete_id    = '0;
        complete_data  = '0;
        complete_miss  = '0;
        complete_taken = '0;
        commit_stall   = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic disp(input logic [DW-1:0] en, input logic [DW-1:0] kind,
                        input logic [DW*LREG_W-1:0] dest);
        dispatch_en   = en;
        dispatch_kind = kind;
        dispatch_dest = dest;
    endtask

    task automatic comp(input int p, input int id, input logic [DATA_W-1:0] data,
                        input bit miss, input bit taken);
        complete_en[p]                    = 1'b1;
        complete_id[p*ID_W +: ID_W]       = ID_W'(id);
        complete_data[p*DATA_W +: DATA_W] = data;
        complete_miss[p]                  = miss;
        complete_taken[p]                 = taken;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step(input bit rst_mid);
        int nret;
        assert (dispatch_en != 2'b10) else $error("non-contiguous dispatch_en");
        model_pre(nret);
        if (rst_mid) begin
            #4 reset = 1'b1;
            #2;
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_commit_en", 64'(commit_en), 64'(0));
            chk("rst_branch_en", 64'(branch_en), 64'(0));
            chk("rst_empty", 64'(empty), 64'(1));
            #2 reset = 1'b0;
            m_q.delete();
            m_head = 0;
            nret   = 0;
        end
        model_post(nret);
        @(negedge clock);
    endtask

    // Monitor: per-cycle status plus a retire record whenever the DUT retires.
    always @(negedge clock) begin
        #2;
        if (mon_on) begin
            dut_any = (commit_en != '0) || branch_en;
            mon_s.any = dut_any;
            if (stat_q.size() == 0) begin
                chk("sb_status_available", 64'(0), 64'(1));
            end else begin
                mon_s = stat_q.pop_front();
                chk("count", 64'(count), 64'(mon_s.cnt));
                chk("empty", 64'(empty), 64'(mon_s.cnt == 0));
                chk("dispatch_reject", 64'(dispatch_reject), 64'(mon_s.rej));
                chk("dispatch_id", 64'(dispatch_id), 64'(mon_s.did));
                chk("retire_any", 64'(dut_any), 64'(mon_s.any));
            end
            if (dut_any) begin
                if (ret_q.size() == 0) begin
                    chk("sb_retire_available", 64'(0), 64'(1));
                end else begin
                    mon_r = ret_q.pop_front();
                    chk("branch_en", 64'(branch_en), 64'(mon_r.br));
                    chk("commit_en", 64'(commit_en), 64'(mon_r.en));
                    if (mon_r.br) begin
                        chk("branch_miss", 64'(branch_miss), 64'(mon_r.miss));
                        chk("branch_taken", 64'(branch_taken), 64'(mon_r.taken));
                        chk("branch_jump_addr", 64'(branch_jump_addr), 64'(mon_r.addr));
                    end
                    for (int k = 0; k < int'(CW); k++) begin
                        if (mon_r.en[k]) begin
                            chk("commit_dest", 64'(commit_dest[k*LREG_W +: LREG_W]),
                                64'(mon_r.dest[k*LREG_W +: LREG_W]));
                            chk("commit_data", 64'(commit_data[k*DATA_W +: DATA_W]),
                                64'(mon_r.data[k*DATA_W +: DATA_W]));
                        end
                    end
                end
            end else if (mon_s.any && ret_q.size() > 0) begin
                void'(ret_q.pop_front());
            end
        end
    end

    initial begin
        int               id;
        int               r;
        logic [DW-1:0]    den, dk;
        m_head = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        mon_on = 1'b1;

        idle(); step(1'b0);

        // Fill to full, then one rejected dispatch.
        for (int c = 0; c < 4; c++) begin
            idle(); disp(2'b11, 2'b00, {5'(2*c+1), 5'(2*c)}); step(1'b0);
        end
        idle(); disp(2'b11, 2'b00, 10'h3ff); step(1'b0);

        // Two ports, out of order, retire together in ID order.
        idle(); comp(0, 1, 32'hAAAA_0001, 1'b0, 1'b0); comp(1, 0, 32'hBBBB_0000, 1'b0, 1'b0); step(1'b0);
        idle(); step(1'b0);
        idle(); step(1'b0);

        // Writeback, mispredicted branch, writeback; flush with the branch.
        idle(); flush = 1'b1; step(1'b0);
        idle(); disp(2'b11, 2'b10, {5'd2, 5'd1}); step(1'b0);
        idle(); disp(2'b01, 2'b00, {5'd0, 5'd3}); step(1'b0);
        idle(); comp(0, 0, 32'h0000_1111, 1'b0, 1'b0); comp(1, 1, 32'h0000_0100, 1'b1, 1'b1); step(1'b0);
        idle(); comp(0, 2, 32'h0000_2222, 1'b0, 1'b0); step(1'b0);
        idle(); flush = 1'b1; step(1'b0);
        idle(); step(1'b0);

        // Advance head to 6, then fill across the wrap to tail=10.
        for (int c = 0; c < 3; c++) begin
            idle(); disp(2'b11, 2'b00, {5'(10+c), 5'(20+c)}); step(1'b0);
        end
        for (int c = 0; c < 3; c++) begin
            idle(); comp(0, 2*c, 32'h600 + 32'(c), 1'b0, 1'b0);
            comp(1, 2*c+1, 32'h700 + 32'(c), 1'b0, 1'b0); step(1'b0);
        end
        idle(); step(1'b0);
        idle(); disp(2'b11, 2'b00, {5'd7, 5'd6}); step(1'b0);
        idle(); disp(2'b11, 2'b00, {5'd9, 5'd8}); step(1'b0);
        idle(); comp(0, 6, 32'hC0DE_0006, 1'b0, 1'b0); comp(1, 7, 32'hC0DE_0007, 1'b0, 1'b0); step(1'b0);
        idle(); step(1'b0);
        idle(); step(1'b0);

        // Stall holds a finished head.
        idle(); commit_stall = 1'b1; comp(0, 0, 32'h5757_0000, 1'b0, 1'b0); step(1'b0);
        idle(); commit_stall = 1'b1; step(1'b0);
        idle(); commit_stall = 1'b1; step(1'b0);
        idle(); step(1'b0);
        idle(); comp(1, 1, 32'h5757_0001, 1'b0, 1'b0); step(1'b0);
        idle(); step(1'b0);

        // Reset between edges with five entries, plus a completion that must be dropped.
        idle(); disp(2'b11, 2'b00, {5'd1, 5'd2}); step(1'b0);
        idle(); disp(2'b11, 2'b00, {5'd3, 5'd4}); step(1'b0);
        idle(); disp(2'b01, 2'b00, {5'd0, 5'd5}); step(1'b0);
        idle(); comp(0, 3, 32'hDEAD_0003, 1'b0, 1'b0); step(1'b1);
        idle(); step(1'b0);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            idle();
            r   = int'($urandom_range(0, 3));
            den = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            dk  = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            disp(den, dk, 10'($urandom));
            for (int p = 0; p < int'(CP); p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                        id = (m_head + int'($urandom_range(0, m_q.size() - 1))) % int'(DEPTH);
                    else
                        id = int'($urandom_range(0, DEPTH - 1));
                    comp(p, id, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            commit_stall = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 59) == 0);
            step($urandom_range(0, 249) == 0);
        end

        mon_on = 1'b0;
        idle();
        #5;
        chk("scoreboard_drained", 64'(stat_q.size() + ret_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/commit_queue_mw.md
Name: commit_queue_mw

Overview:
- Parametrised, multi-width in-order commit queue (reorder buffer) between dispatch/rename and the register file / branch unit.
- Accepts up to DISPATCH_W entries per cycle and COMPLETE_P out-of-order completions per cycle, and retires up to COMMIT_W finished entries per cycle in program order.
- Full and empty are distinguished with wrap-bit pointers.
- Provides occupancy, synchronous flush and a commit stall input.

Parameters:
- DEPTH, 64, entry count; power of two, at least 4.
- ID_W, $clog2(DEPTH), commit-ID width.
- DISPATCH_W, 2, dispatch lanes.
- COMPLETE_P, 2, completion ports.
- COMMIT_W, 2, retire lanes.
- DATA_W, 32, writeback data and jump-address width.
- LREG_W, 5, logical register index width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous discard of all entries.
- dispatch_en  in  DISPATCH_W  lane valid; lanes are contiguous from lane 0.
- dispatch_kind  in  DISPATCH_W  per lane: 0 = writeback, 1 = branch.
- dispatch_dest  in  DISPATCH_W*LREG_W  logical destination per lane.
- dispatch_reject  out  1  queue cannot take DISPATCH_W entries this cycle.
- dispatch_id  out  ID_W  ID assigned to lane 0; lane i receives (dispatch_id+i) mod DEPTH.
- complete_en  in  COMPLETE_P  completion valid per port.
- complete_id  in  COMPLETE_P*ID_W  target entry per port.
- complete_data  in  COMPLETE_P*DATA_W  writeback data, or new PC for a branch.
- complete_miss, complete_taken  in  COMPLETE_P each  branch outcome per port.
- commit_stall  in  1  when 1, nothing retires.
- commit_en  out  COMMIT_W  retire lane valid.
- commit_dest  out  COMMIT_W*LREG_W  logical destination per retire lane.
- commit_data  out  COMMIT_W*DATA_W  writeback data per retire lane.
- branch_en  out  1  a branch retires this cycle, always in lane 0.
- branch_miss, branch_taken  out  1 each  outcome of the retiring branch.
- branch_jump_addr  out  DATA_W  new PC of the retiring branch.
- count  out  ID_W+1  occupancy, 0..DEPTH.
- empty  out  1  count==0.

Behaviour:
- State:
  - head and tail pointers, ID_W+1 bits each; the MSB is the wrap bit.
  - Per entry: valid, fin, kind, dest, data, miss, taken.
  - count = tail-head, modulo 2^(ID_W+1).
  - Full is count==DEPTH; empty is head==tail, including the wrap bit.
- Reset (asynchronous): pointers 0, all valid/fin bits 0. Outputs read commit_en=0, branch_en=0, count=0, empty=1, dispatch_reject=0, dispatch_id=0.
- Dispatch:
  - dispatch_reject = (DEPTH-count) < DISPATCH_W, combinational. Acceptance is all-or-nothing.
  - If not rejected, lanes with dispatch_en=1 are written at tail+i with valid=1, fin=0, and tail advances by popcount(dispatch_en).
  - Non-contiguous dispatch_en is illegal; the bench asserts it never occurs.
- Completion:
  - Sets fin=1 and stores data/miss/taken in the addressed entry on the next edge.
  - Completion to an entry with valid=0 is ignored.
  - Two ports hitting the same ID in one cycle: the higher port index wins.
  - Completion to an entry retiring in the same cycle is ignored; the entry is already fin.
- Retire (combinational from registered state, i.e. one cycle after the completing edge):
  - Lane k is valid iff all of:
    - commit_stall=0;
    - head+k < tail;
    - entries head..head+k all valid and fin;
    - no branch entry at head+j for 0<j<=k;
    - the head entry is not a branch when k>0.
  - A branch therefore retires alone in lane 0: branch_en=1 and commit_en=0 for all lanes. Branch entries never drive commit_en.
  - Head advances by the number of retiring entries; their valid bits are cleared.
  - A retiring branch with miss=1 does not flush internally. The pipeline asserts flush; entries behind it keep retiring only if the pipeline lets them.
- Simultaneous dispatch and retire: both apply. dispatch_reject uses the pre-retire count, which is conservative.
- Flush (synchronous): dominates dispatch, completion and retire in the same cycle. Next cycle pointers are 0, valid is 0, and all outputs are at their reset values.
- Wrap-around: indices are taken modulo DEPTH and the wrap bit toggles. Retiring lanes may span the DEPTH-1 to 0 boundary within one cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Test Plan:
- DEPTH=8: dispatch 2/cycle for 4 cycles with no completion -> count=8, dispatch_reject=1. A further dispatch leaves tail unchanged; empty=0.
- Complete IDs 1 and 0 on two ports in one cycle (both writeback) -> next cycle commit_en=2'b11 with data in ID order; head=2, count=6.
- Entries 0 writeback, 1 branch (miss=1, new_pc=0x100), 2 writeback, all fin -> cycle A commit_en=2'b01; cycle B branch_en=1, branch_miss=1, jump_addr=0x100; assert flush -> next cycle count=0, empty=1.
- Fill/retire to head=6, tail=10 (wrap), IDs 6,7 fin -> both retire in one cycle; head=8 (index 0); dispatch_id=2.
- commit_stall=1 with head fin -> commit_en=0 and head unchanged; release -> retire on the next cycle.
- Assert reset between edges with count=5 -> count=0 and commit_en=0 immediately; same-port completion to a now-invalid ID is ignored.
